// File: rtl/miner_pkg.sv
// Shared definitions for the nonce dispatcher.
// Contents:
//   DEF_CORES / DEF_NONCE_W : default lane count and nonce width.
//   state_t                 : dispatcher FSM state encoding.
package miner_pkg;

    localparam int DEF_CORES   = 4;
    localparam int DEF_NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/miner_nonce_dispatcher_if.sv
// Handshake bundle between the nonce dispatcher and the hash-core array.
// Signals:
//   core_valid [CORES]          : per-lane nonce valid (dispatcher -> cores)
//   core_ready [CORES]          : per-lane ready (cores -> dispatcher)
//   core_nonce [CORES*NONCE_W]  : lane c at bits [c*NONCE_W +: NONCE_W]
// Modports: master = dispatcher side, slave = hash-core side.
interface miner_nonce_dispatcher_if #(
    parameter int CORES   = 4,
    parameter int NONCE_W = 32
);

    logic [CORES-1:0]         core_valid;
    logic [CORES-1:0]         core_ready;
    logic [CORES*NONCE_W-1:0] core_nonce;

    modport master (
        output core_valid,
        output core_nonce,
        input  core_ready
    );

    modport slave (
        input  core_valid,
        input  core_nonce,
        output core_ready
    );

endinterface

// File: rtl/miner_nonce_lane.sv
// One dispatcher lane: holds the current nonce and its valid flag, and
// steps by CORES on every accepted handshake until the range end is passed.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : latch base_nonce + LANE as the first nonce of a run
//   clear         : drop valid (run aborted)
//   ready         : core ready for this lane
//   base_nonce    : range start (used with load)
//   end_nonce     : inclusive range end
//   valid, nonce  : registered lane outputs
//   valid_next    : value valid will take at the next edge (excludes rst)
module miner_nonce_lane #(
    parameter int NONCE_W = 32,
    parameter int CORES   = 4,
    parameter int LANE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               ready,
    input  logic [NONCE_W-1:0] base_nonce,
    input  logic [NONCE_W-1:0] end_nonce,
    output logic               valid,
    output logic [NONCE_W-1:0] nonce,
    output logic               valid_next
);

    localparam logic [NONCE_W:0] LANE_OFS = (NONCE_W+1)'(LANE);
    localparam logic [NONCE_W:0] STRIDE   = (NONCE_W+1)'(CORES);

    logic [NONCE_W:0]   load_sum;
    logic [NONCE_W:0]   adv_sum;
    logic [NONCE_W:0]   end_ext;
    logic [NONCE_W-1:0] nonce_d;
    logic               valid_d;

    // Sums are one bit wider than the nonce. end_ext always has a zero MSB,
    // so a single "<= end_ext" compare also rejects any carry-out: the lane
    // finishes instead of wrapping to 0.
    always_comb begin
        load_sum = {1'b0, base_nonce} + LANE_OFS;
        adv_sum  = {1'b0, nonce} + STRIDE;
        end_ext  = {1'b0, end_nonce};
        valid_d  = valid;
        nonce_d  = nonce;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            if (load_sum <= end_ext) begin
                valid_d = 1'b1;
                nonce_d = load_sum[NONCE_W-1:0];
            end else begin
                valid_d = 1'b0;
                nonce_d = base_nonce;
            end
        end else if (valid && ready) begin
            if (adv_sum <= end_ext) begin
                nonce_d = adv_sum[NONCE_W-1:0];
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    assign valid_next = valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            nonce <= '0;
        end else begin
            valid <= valid_d;
            nonce <= nonce_d;
        end
    end

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// Multi-lane nonce range generator. Lane c issues base+c, base+c+CORES, ...
// up to end_nonce inclusive, over a per-lane valid/ready handshake.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : pulse, latch range and begin a run (ignored in RUN)
//   abort                    : end a run without done
//   base_nonce, end_nonce    : inclusive nonce range
//   core (master modport)    : core_valid / core_ready / core_nonce
//   busy                     : FSM in RUN
//   done                     : range fully issued, held until next start/rst
//   issued_count             : handshakes since last start (MINER_NONCE_STATS_EN only)
// Optional feature macro: MINER_NONCE_STATS_EN enables issued_count.
//
// state | meaning
// IDLE  | no run in progress, outputs quiet
// RUN   | lanes issuing nonces
// DONE  | every lane passed end_nonce, done held
module miner_nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int CORES   = DEF_CORES,
    parameter int NONCE_W = DEF_NONCE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] base_nonce,
    input  logic [NONCE_W-1:0] end_nonce,
    miner_nonce_dispatcher_if.master core,
    output logic               busy,
    output logic               done
`ifdef MINER_NONCE_STATS_EN
    ,
    output logic [NONCE_W:0]   issued_count
`endif
);

    state_t                   state;
    logic                     in_run;
    logic                     start_ok;
    logic                     lane_clear;
    logic                     all_finished;
    logic [CORES-1:0]         valid_vec;
    logic [CORES-1:0]         valid_next_vec;
    logic [CORES*NONCE_W-1:0] nonce_vec;

    assign in_run     = (state == RUN);
    assign start_ok   = start && !in_run;
    assign lane_clear = abort && in_run;

    for (genvar c = 0; c < CORES; c++) begin : g_lane
        miner_nonce_lane #(
            .NONCE_W (NONCE_W),
            .CORES   (CORES),
            .LANE    (c)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load       (start_ok),
            .clear      (lane_clear),
            .ready      (core.core_ready[c]),
            .base_nonce (base_nonce),
            .end_nonce  (end_nonce),
            .valid      (valid_vec[c]),
            .nonce      (nonce_vec[c*NONCE_W +: NONCE_W]),
            .valid_next (valid_next_vec[c])
        );
    end

    assign core.core_valid = valid_vec;
    assign core.core_nonce = nonce_vec;

    // Looking at next-cycle lane valids lets done rise in the cycle right
    // after the last handshake, and lets an empty range finish one cycle
    // after start.
    assign all_finished = ~|valid_next_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (all_finished) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MINER_NONCE_STATS_EN
    logic [NONCE_W:0]   hs_pop;
    logic [NONCE_W+1:0] cnt_sum;

    // One extra bit on the sum makes the saturation test a single MSB check.
    always_comb begin
        hs_pop = '0;
        for (int c = 0; c < CORES; c++) begin
            hs_pop = hs_pop + (NONCE_W+1)'(valid_vec[c] & core.core_ready[c]);
        end
        cnt_sum = {1'b0, issued_count} + {1'b0, hs_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_count <= '0;
        end else if (start_ok) begin
            issued_count <= '0;
        end else if (cnt_sum[NONCE_W+1]) begin
            issued_count <= '1;
        end else begin
            issued_count <= cnt_sum[NONCE_W:0];
        end
    end
`endif

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
module tb_miner_nonce_dispatcher;

    localparam int CORES = 4;
    localparam int NW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NW-1:0] base_nonce;
    logic [NW-1:0] end_nonce;
    logic          busy;
    logic          done;
`ifdef MINER_NONCE_STATS_EN
    logic [NW:0]   issued_count;
`endif

    miner_nonce_dispatcher_if #(.CORES(CORES), .NONCE_W(NW)) bus ();

    miner_nonce_dispatcher #(.CORES(CORES), .NONCE_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_nonce (base_nonce),
        .end_nonce  (end_nonce),
        .core       (bus),
        .busy       (busy),
        .done       (done)
`ifdef MINER_NONCE_STATS_EN
        ,
        .issued_count (issued_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    longint unsigned exp_q [CORES][$];
    longint unsigned exp_total;

    function automatic logic [NW-1:0] lane_nonce(input int c);
        return bus.core_nonce[c*NW +: NW];
    endfunction

    // Reference model: enumerate every nonce of each lane at 64-bit width.
    task automatic push_range(input longint unsigned b, input longint unsigned e);
        exp_total = 0;
        for (int c = 0; c < CORES; c++) begin
            longint unsigned n;
            exp_q[c].delete();
            n = b + longint'(c);
            while (n <= e) begin
                exp_q[c].push_back(n);
                exp_total++;
                n += CORES;
            end
        end
    endtask

    task automatic launch(input logic [NW-1:0] b, input logic [NW-1:0] e);
        push_range(b, e);
        base_nonce = b;
        end_nonce  = e;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Runs from cycle 1 of a run until done, comparing every presented nonce
    // with the scoreboard head and popping it on handshake.
    task automatic drain(input int hold_lane, input int hold_cycles, input int exp_done_cyc);
        int done_cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            for (int c = 0; c < CORES; c++)
                bus.core_ready[c] = (c == hold_lane && k <= hold_cycles) ? 1'b0 : 1'b1;
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_in_run cycle %0d got %b exp 1", k, busy);
            else n_pass++;
            for (int c = 0; c < CORES; c++) begin
                if (bus.core_valid[c] === 1'b1) begin
                    n_checks++;
                    if (exp_q[c].size() == 0)
                        $display("FAIL unexpected_valid lane %0d cycle %0d got %h exp none", c, k, lane_nonce(c));
                    else if (longint'(lane_nonce(c)) !== exp_q[c][0])
                        $display("FAIL nonce lane %0d cycle %0d got %h exp %h", c, k, lane_nonce(c), exp_q[c][0]);
                    else n_pass++;
                    if (bus.core_ready[c] && exp_q[c].size() > 0) void'(exp_q[c].pop_front());
                end
            end
            @(negedge clk);
        end
        for (int c = 0; c < CORES; c++) bus.core_ready[c] = 1'b1;
        n_checks++;
        if (done_cyc !== exp_done_cyc) $display("FAIL done_cycle got %0d exp %0d", done_cyc, exp_done_cyc);
        else n_pass++;
        n_checks++;
        if (bus.core_valid !== '0 || busy !== 1'b0)
            $display("FAIL quiet_at_done valid %b busy %b exp 0000 0", bus.core_valid, busy);
        else n_pass++;
        for (int c = 0; c < CORES; c++) begin
            n_checks++;
            if (exp_q[c].size() != 0) $display("FAIL lane_left lane %0d got %0d pending exp 0", c, exp_q[c].size());
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        base_nonce = '0; end_nonce = '0; bus.core_ready = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.core_valid !== '0) $display("FAIL reset_valid got %b exp 0", bus.core_valid); else n_pass++;
        n_checks++;
        if (bus.core_nonce !== '0) $display("FAIL reset_nonce got %h exp 0", bus.core_nonce); else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_status busy %b done %b exp 0 0", busy, done); else n_pass++;
`ifdef MINER_NONCE_STATS_EN
        n_checks++;
        if (issued_count !== '0) $display("FAIL reset_count got %0d exp 0", issued_count); else n_pass++;
`endif
    endtask

    task automatic test_basic();
        launch(32'd100, 32'd107);
        drain(-1, 0, 3);
`ifdef MINER_NONCE_STATS_EN
        n_checks++;
        if (issued_count !== (NW+1)'(exp_total)) $display("FAIL issued_count got %0d exp %0d", issued_count, exp_total);
        else n_pass++;
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL abort_in_done done %b busy %b exp 1 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        launch(32'd100, 32'd107);
        drain(1, 3, 6);
    endtask

    task automatic test_overflow();
        launch(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        drain(-1, 0, 2);
    endtask

    task automatic test_empty_range();
        launch(32'd50, 32'd40);
        drain(-1, 0, 2);
    endtask

    task automatic test_abort();
        launch(32'd1000, 32'd1099);
        for (int k = 1; k <= 2; k++) begin
            if (k == 2) abort = 1'b1;
            for (int c = 0; c < CORES; c++) begin
                n_checks++;
                if (bus.core_valid[c] !== 1'b1 || longint'(lane_nonce(c)) !== exp_q[c][0])
                    $display("FAIL abort_run lane %0d cycle %0d got %b/%h exp 1/%h", c, k, bus.core_valid[c], lane_nonce(c), exp_q[c][0]);
                else n_pass++;
                void'(exp_q[c].pop_front());
            end
            @(negedge clk);
        end
        abort = 1'b0;
        n_checks++;
        if (bus.core_valid !== '0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL after_abort valid %b busy %b done %b exp 0000 0 0", bus.core_valid, busy, done);
        else n_pass++;
`ifdef MINER_NONCE_STATS_EN
        n_checks++;
        if (issued_count !== (NW+1)'(8)) $display("FAIL abort_count got %0d exp 8", issued_count); else n_pass++;
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_in_idle busy %b done %b exp 0 0", busy, done);
        else n_pass++;
        launch(32'd2000, 32'd2003);
        drain(-1, 0, 2);
    endtask

    task automatic test_reset_mid();
        launch(32'd0, 32'd999);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; base_nonce = 32'd5000; end_nonce = 32'd6000;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if (bus.core_valid !== '0 || bus.core_nonce !== '0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid valid %b nonce %h busy %b done %b exp all 0", bus.core_valid, bus.core_nonce, busy, done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.core_valid !== '0 || busy !== 1'b0)
            $display("FAIL start_with_rst valid %b busy %b exp 0000 0", bus.core_valid, busy);
        else n_pass++;
        for (int c = 0; c < CORES; c++) exp_q[c].delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_empty_range();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
